enemy_hit: RTL

Per-enemy damage and health tracker that sits directly downstream of the weapon stage. It consumes the registered weapon state and position, tests them against one enemy's hitbox, and applies type-dependent damage. It also runs a hurt/invulnerability window and a dying sequence, and emits hit/kill pulses for score and sound logic. One instance is placed per enemy slot.

---
 rtl/game_pkg.sv | 38 +++
 rtl/hitbox_cmp.sv | 25 ++
 rtl/enemy_hit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game encodings: weapon states, stage codes, enemy FSM states, damage table
package game_pkg;

    typedef enum logic [3:0] {
        WOODEN_0 = 4'h0, WOODEN_1 = 4'h1, WOODEN_2 = 4'h2, WOODEN_3 = 4'h3,
        BASYS_0  = 4'h4, BASYS_1  = 4'h5, BASYS_2  = 4'h6, BASYS_3  = 4'h7,
        CAR_0    = 4'h8, CAR_1    = 4'h9, CAR_2    = 4'hA, CAR_3    = 4'hB,
        EMPTY    = 4'hF
    } weapon_state_t;

    localparam logic [3:0] STAGE_TITLE = 4'h0;
    localparam logic [3:0] STAGE_END   = 4'hF;

    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_ALIVE = 2'd1,
        E_HURT  = 2'd2,
        E_DYING = 2'd3
    } enemy_state_t;

    localparam logic [3:0] DMG_NONE   = 4'd0;
    localparam logic [3:0] DMG_WOODEN = 4'd1;
    localparam logic [3:0] DMG_BASYS  = 4'd2;
    localparam logic [3:0] DMG_CAR    = 4'd3;

    function automatic logic [3:0] weapon_damage(input logic [3:0] ws);
        if (ws <= CAR_3) begin
            if (ws <= WOODEN_3)
                return DMG_WOODEN;
            else if (ws <= BASYS_3)
                return DMG_BASYS;
            else
                return DMG_CAR;
        end
        return DMG_NONE;
    endfunction

endpackage

// File: rtl/hitbox_cmp.sv
// rtl/hitbox_cmp.sv - combinational square-window overlap test between two 10-bit positions
module hitbox_cmp #(
    parameter int HIT_RANGE = 16
) (
    input  logic [9:0] a_h,
    input  logic [9:0] a_v,
    input  logic [9:0] b_h,
    input  logic [9:0] b_v,
    output logic       overlap
);

    logic signed [10:0] diff_h;
    logic signed [10:0] diff_v;
    logic        [10:0] dist_h;
    logic        [10:0] dist_v;

    // Zero-extended 11-bit difference spans -1023..1023, so it never wraps.
    assign diff_h = $signed({1'b0, a_h}) - $signed({1'b0, b_h});
    assign diff_v = $signed({1'b0, a_v}) - $signed({1'b0, b_v});
    assign dist_h = diff_h[10] ? 11'(-diff_h) : 11'(diff_h);
    assign dist_v = diff_v[10] ? 11'(-diff_v) : 11'(diff_v);

    assign overlap = (dist_h < 11'(HIT_RANGE)) && (dist_v < 11'(HIT_RANGE));

endmodule

// File: rtl/enemy_hit.sv
// rtl/enemy_hit.sv - per-enemy health tracker with hurt window, dying sequence and hit/kill pulses
module enemy_hit
    import game_pkg::*;
#(
    parameter int MAX_HP      = 4,
    parameter int HIT_RANGE   = 16,
    parameter int IFRAMES     = 8,
    parameter int DYING_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] stage,
    input  logic       tick,
    input  logic       spawn,
    input  logic [3:0] w_state,
    input  logic [9:0] w_pos_h,
    input  logic [9:0] w_pos_v,
    input  logic [9:0] e_pos_h,
    input  logic [9:0] e_pos_v,
    output logic [3:0] e_hp,
    output logic       e_alive,
    output logic       e_flash,
    output logic       e_dying,
    output logic       e_hit,
    output logic       e_kill
);

    localparam int CNT_MAX = (IFRAMES > DYING_TICKS) ? IFRAMES : DYING_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    enemy_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       damage;
    logic             overlap;
    logic             stage_gate;
    logic             strike;

    hitbox_cmp #(
        .HIT_RANGE(HIT_RANGE)
    ) u_hitbox (
        .a_h    (w_pos_h),
        .a_v    (w_pos_v),
        .b_h    (e_pos_h),
        .b_v    (e_pos_v),
        .overlap(overlap)
    );

    assign damage     = weapon_damage(w_state);
    assign stage_gate = (stage == STAGE_TITLE) || (stage == STAGE_END);
    assign strike     = (state == E_ALIVE) && (damage != DMG_NONE) && overlap;

    // Gate and reset share the same clear so a gate never produces a kill pulse.
    always_ff @(posedge clk) begin
        if (rst || stage_gate) begin
            state   <= E_IDLE;
            e_hp    <= 4'd0;
            cnt     <= '0;
            e_alive <= 1'b0;
            e_flash <= 1'b0;
            e_dying <= 1'b0;
            e_hit   <= 1'b0;
            e_kill  <= 1'b0;
        end else begin
            e_hit  <= 1'b0;
            e_kill <= 1'b0;
            case (state)
                E_IDLE: begin
                    if (spawn) begin
                        state   <= E_ALIVE;
                        e_hp    <= 4'(MAX_HP);
                        e_alive <= 1'b1;
                    end
                end
                E_ALIVE: begin
                    // A same-cycle tick is irrelevant here: the counter loads its full value.
                    if (strike) begin
                        e_hit <= 1'b1;
                        if (damage < e_hp) begin
                            state   <= E_HURT;
                            e_hp    <= e_hp - damage;
                            cnt     <= CNT_W'(IFRAMES);
                            e_flash <= 1'b1;
                        end else begin
                            state   <= E_DYING;
                            e_hp    <= 4'd0;
                            cnt     <= CNT_W'(DYING_TICKS);
                            e_alive <= 1'b0;
                            e_dying <= 1'b1;
                            e_kill  <= 1'b1;
                        end
                    end
                end
                E_HURT: begin
                    if (tick) begin
                        if (cnt == CNT_W'(1)) begin
                            state   <= E_ALIVE;
                            cnt     <= '0;
                            e_flash <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                E_DYING: begin
                    if (tick) begin
                        if (cnt == CNT_W'(1)) begin
                            state   <= E_IDLE;
                            cnt     <= '0;
                            e_dying <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: state <= E_IDLE;
            endcase
        end
    end

endmodule
